// File: rtl/calibracion_multicanal.sv
// calibracion_multicanal: per-channel gain/offset calibration of raw ADC words into saturated signed fixed point
module calibracion_multicanal #(
    parameter int N_CH       = 3,
    parameter int ADC_W      = 12,
    parameter int GAIN_W     = 24,
    parameter int GAIN_SHIFT = 12,
    parameter int INT_BITS   = 20,
    parameter int FRAC_BITS  = 17,
    localparam int OUT_W     = INT_BITS + FRAC_BITS + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    CE,
    input  logic                    start,
    input  logic [N_CH*ADC_W-1:0]   adc_in,
    input  logic                    cfg_we,
    input  logic [3:0]              cfg_sel,
    input  logic [GAIN_W-1:0]       cfg_gain,
    input  logic [OUT_W-1:0]        cfg_offset,
    output logic [N_CH*OUT_W-1:0]   data_out,
    output logic                    valid,
    output logic                    busy,
    output logic [N_CH-1:0]         sat_flags,
    output logic                    overrun
);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PROD_W = ADC_W + GAIN_W;
    localparam int SUM_W  = OUT_W + GAIN_W + ADC_W;
    localparam int SH     = FRAC_BITS - GAIN_SHIFT;
    localparam logic signed [SUM_W-1:0] MAX_S = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_S = ~MAX_S;
    localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(1) << GAIN_SHIFT;
    localparam logic [CH_W-1:0] LAST = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    state_t              state_q;
    logic [CH_W-1:0]     ch_q;
    logic [PROD_W-1:0]   prod_q;
    logic [ADC_W-1:0]    adc_q      [N_CH];
    logic [GAIN_W-1:0]   cfg_gain_q [N_CH];
    logic [OUT_W-1:0]    cfg_off_q  [N_CH];
    logic [GAIN_W-1:0]   act_gain_q [N_CH];
    logic [OUT_W-1:0]    act_off_q  [N_CH];
    logic [OUT_W-1:0]    shadow_q   [N_CH];
    logic [OUT_W-1:0]    data_q     [N_CH];
    logic [N_CH-1:0]     shadow_sat_q;
    logic [N_CH-1:0]     sat_q;
    logic                valid_q;
    logic                busy_q;
    logic                overrun_q;
    logic [PROD_W-1:0]   prod_d;
    logic signed [SUM_W-1:0] sum_d;
    logic [OUT_W-1:0]    res_d;
    logic                sat_d;
    logic                cfg_ok;
    logic [CH_W-1:0]     cfg_idx;

    assign cfg_ok  = {1'b0, cfg_sel} < 5'(N_CH);
    assign cfg_idx = cfg_sel[CH_W-1:0];

    // Datapath for the current channel: shared multiplier, offset alignment and saturation
    always_comb begin
        prod_d = PROD_W'(adc_q[ch_q]) * PROD_W'(act_gain_q[ch_q]);
        sum_d  = $signed(SUM_W'(prod_q) << SH)
               + $signed({{(SUM_W-OUT_W){act_off_q[ch_q][OUT_W-1]}}, act_off_q[ch_q]});
        sat_d  = (sum_d > MAX_S) || (sum_d < MIN_S);
        res_d  = (sum_d > MAX_S) ? MAX_S[OUT_W-1:0] :
                 (sum_d < MIN_S) ? MIN_S[OUT_W-1:0] : sum_d[OUT_W-1:0];
    end

    // Configuration bank, sequencer and output registers; valid clears on every non-DONE edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            prod_q       <= '0;
            shadow_sat_q <= '0;
            sat_q        <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                adc_q[i]      <= '0;
                cfg_gain_q[i] <= GAIN_ONE;
                cfg_off_q[i]  <= '0;
                act_gain_q[i] <= GAIN_ONE;
                act_off_q[i]  <= '0;
                shadow_q[i]   <= '0;
                data_q[i]     <= '0;
            end
        end else begin
            valid_q <= CE && (state_q == DONE);
            if (CE) begin
                if (cfg_we && cfg_ok) begin
                    cfg_gain_q[cfg_idx] <= cfg_gain;
                    cfg_off_q[cfg_idx]  <= cfg_offset;
                end
                if (start && busy_q)
                    overrun_q <= 1'b1;
                case (state_q)
                    IDLE: if (start) begin
                        for (int i = 0; i < N_CH; i++)
                            adc_q[i] <= adc_in[i*ADC_W +: ADC_W];
                        act_gain_q <= cfg_gain_q;
                        act_off_q  <= cfg_off_q;
                        ch_q       <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= MUL;
                    end
                    MUL: begin
                        prod_q  <= prod_d;
                        state_q <= ACC;
                    end
                    ACC: begin
                        shadow_q[ch_q]     <= res_d;
                        shadow_sat_q[ch_q] <= sat_d;
                        if (ch_q == LAST) begin
                            state_q <= DONE;
                        end else begin
                            ch_q    <= ch_q + CH_W'(1);
                            state_q <= MUL;
                        end
                    end
                    DONE: begin
                        data_q  <= shadow_q;
                        sat_q   <= shadow_sat_q;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign data_out[g*OUT_W +: OUT_W] = data_q[g];
    end

    assign valid     = valid_q;
    assign busy      = busy_q;
    assign sat_flags = sat_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_calibracion_multicanal.sv
// tb_calibracion_multicanal: directed vector and sequence checks for the calibration stage
module tb_calibracion_multicanal;
    localparam int N = 3;
    localparam int AW = 12;
    localparam int GW = 24;
    localparam int OW = 38;

    logic              clk;
    logic              rst;
    logic              CE;
    logic              start;
    logic [N*AW-1:0]   adc_in;
    logic              cfg_we;
    logic [3:0]        cfg_sel;
    logic [GW-1:0]     cfg_gain;
    logic [OW-1:0]     cfg_offset;
    logic [N*OW-1:0]   data_out;
    logic              valid;
    logic              busy;
    logic [N-1:0]      sat_flags;
    logic              overrun;

    int n_chk = 0;
    int n_fail = 0;

    calibracion_multicanal dut (
        .clk(clk), .rst(rst), .CE(CE), .start(start), .adc_in(adc_in),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_gain(cfg_gain), .cfg_offset(cfg_offset),
        .data_out(data_out), .valid(valid), .busy(busy), .sat_flags(sat_flags), .overrun(overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]    wsel;
        logic [GW-1:0] gain;
        logic [OW-1:0] off;
        logic [AW-1:0] adc;
        int            chn;
        logic [OW-1:0] exp_d;
        logic          exp_s;
    } vec_t;

    vec_t vt[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [OW-1:0] ch_out(input int c);
        return data_out[c*OW +: OW];
    endfunction

    task automatic write_cfg(input logic [3:0] sel, input logic [GW-1:0] g, input logic [OW-1:0] o);
        cfg_we = 1'b1;
        cfg_sel = sel;
        cfg_gain = g;
        cfg_offset = o;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic run_conv(output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'd7);
    endtask

    initial begin
        int lat;
        vt[0] = '{4'd1, 24'h00A000, 38'(-2621440), 12'd100, 1, 38'd128450560, 1'b0};
        vt[1] = '{4'd2, 24'hFFFFFF, 38'd0, 12'd4095, 2, 38'h1F_FFFF_FFFF, 1'b1};
        vt[2] = '{4'd2, 24'h001000, 38'd0, 12'd4095, 2, 38'd536739840, 1'b0};
        vt[3] = '{4'd0, 24'h000000, 38'h20_0000_0000, 12'd123, 0, 38'h20_0000_0000, 1'b0};
        vt[4] = '{4'd1, 24'h000000, 38'h1F_FFFF_FFFF, 12'd77, 1, 38'h1F_FFFF_FFFF, 1'b0};
        vt[5] = '{4'd1, 24'h000001, 38'h1F_FFFF_FFFF, 12'd1, 1, 38'h1F_FFFF_FFFF, 1'b1};
        vt[6] = '{4'd0, 24'h001800, 38'h20000, 12'd1000, 0, 38'd196739072, 1'b0};
        vt[7] = '{4'd4, 24'h000000, 38'd0, 12'd1000, 0, 38'd196739072, 1'b0};

        rst = 1'b0; CE = 1'b1; start = 1'b0; adc_in = '0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_gain = '0; cfg_offset = '0;
        tick();
        tick();
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sat", 64'(sat_flags), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        rst = 1'b1;
        tick();

        adc_in = {12'd0, 12'd0, 12'd4095};
        start = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            tick();
            start = 1'b0;
            chk($sformatf("dflt_valid_e%0d", k), 64'(valid), 64'(k == 7));
            chk($sformatf("dflt_busy_e%0d", k), 64'(busy), 64'(k < 7));
        end
        chk("dflt_ch0", 64'(ch_out(0)), 64'd536739840);
        chk("dflt_sat", 64'(sat_flags), 64'd0);

        for (int i = 0; i < 8; i++) begin
            write_cfg(vt[i].wsel, vt[i].gain, vt[i].off);
            adc_in = {N{vt[i].adc}};
            run_conv(lat);
            chk($sformatf("vec%0d_data", i), 64'(ch_out(vt[i].chn)), 64'(vt[i].exp_d));
            chk($sformatf("vec%0d_sat", i), 64'(sat_flags[vt[i].chn]), 64'(vt[i].exp_s));
        end

        for (int k = 0; k <= 16; k++) begin
            start = (k == 0) || (k == 3) || (k == 8);
            tick();
            start = 1'b0;
            chk($sformatf("ovr_valid_e%0d", k), 64'(valid), 64'((k == 7) || (k == 15)));
            chk($sformatf("ovr_flag_e%0d", k), 64'(overrun), 64'(k >= 3));
        end

        write_cfg(4'd0, 24'h001000, 38'd0);
        adc_in = {12'd0, 12'd0, 12'd1000};
        for (int k = 0; k <= 10; k++) begin
            start = (k == 0);
            cfg_we = (k == 2);
            cfg_sel = 4'd0;
            cfg_gain = 24'h002000;
            cfg_offset = 38'd0;
            CE = !((k == 4) || (k == 5) || (k == 10));
            tick();
            start = 1'b0;
            cfg_we = 1'b0;
            CE = 1'b1;
            chk($sformatf("stall_valid_e%0d", k), 64'(valid), 64'(k == 9));
            if (k >= 1 && k <= 8)
                chk($sformatf("stall_busy_e%0d", k), 64'(busy), 64'd1);
        end
        chk("stall_old_gain", 64'(ch_out(0)), 64'd131072000);
        run_conv(lat);
        chk("stall_new_gain", 64'(ch_out(0)), 64'd262144000);

        adc_in = {3{12'd4095}};
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_data", 64'(data_out), 64'd0);
        chk("abort_overrun", 64'(overrun), 64'd0);
        begin
            logic seen = 1'b0;
            for (int k = 0; k < 8; k++) begin
                seen |= valid;
                tick();
            end
            chk("abort_no_valid", 64'(seen), 64'd0);
        end
        run_conv(lat);
        for (int c = 0; c < N; c++)
            chk($sformatf("abort_dflt_ch%0d", c), 64'(ch_out(c)), 64'd536739840);
        chk("abort_dflt_sat", 64'(sat_flags), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/calibracion_multicanal.md
Name: calibracion_multicanal

Overview:
- Parametrised successor to the fixed three-channel ADC adaptation stage.
- Converts N_CH raw unsigned ADC words into signed Q(INT_BITS).(FRAC_BITS) fixed point: y = adc*gain + offset.
- Gain and offset are runtime-programmable per channel; results saturate on overflow.
- Uses one time-multiplexed multiplier and is triggered per sample by start (sync/trigger from the PWM actuator); feeds the controller.

Parameters:
- N_CH, 3, number of channels (1..16)
- ADC_W, 12, raw ADC word width (unsigned)
- GAIN_W, 24, gain width, unsigned fixed point
- GAIN_SHIFT, 12, fractional bits of gain (must be <= FRAC_BITS)
- INT_BITS, 20, output integer bits excluding sign (output width OUT_W = INT_BITS+FRAC_BITS+1 = 38)
- FRAC_BITS, 17, output fractional bits

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- CE  in  1  clock enable; when 0, every register except valid holds
- start  in  1  sample strobe; sampled only in IDLE
- adc_in  in  N_CH*ADC_W  raw channels, ch0 in LSBs
- cfg_we  in  1  coefficient write strobe
- cfg_sel  in  4  channel index for the write
- cfg_gain  in  GAIN_W  gain value to write
- cfg_offset  in  OUT_W  signed offset, Q(INT_BITS).(FRAC_BITS)
- data_out  out  N_CH*OUT_W  signed results, ch0 in LSBs
- valid  out  1  one-cycle pulse when data_out updates
- busy  out  1  high while not IDLE
- sat_flags  out  N_CH  per channel, 1 = last result clamped
- overrun  out  1  sticky; start seen while busy

Behaviour:
- Reset (rst=0 at an edge):
  - data_out, sat_flags, valid, busy and overrun go to 0; FSM goes to IDLE.
  - Configuration gains reset to 1.0 (1<<GAIN_SHIFT); offsets reset to 0.
  - Reset aborts any conversion in progress; no valid pulse is produced for it.
- Configuration bank:
  - On an edge with CE=1, cfg_we=1 and cfg_sel<N_CH, write cfg_gain/cfg_offset for channel cfg_sel. Writes with cfg_sel>=N_CH are ignored.
  - The active bank is copied from the configuration bank at the start edge. A write during busy therefore affects only the next conversion.
  - A write on the start edge itself is not included in that conversion.
- FSM (all transitions require CE=1):
  - IDLE: when start=1, latch adc_in and the coefficient bank, set ch=0, go to MUL.
  - MUL: prod <= adc[ch]*gain[ch], unsigned, ADC_W+GAIN_W bits. Go to ACC.
  - ACC: sum = (prod << (FRAC_BITS-GAIN_SHIFT)) + sign-extended offset[ch], computed in OUT_W+GAIN_W+ADC_W bits, no overflow possible internally.
    - If sum > 2^(OUT_W-1)-1, clamp to that value and set shadow_sat[ch]=1; if sum < -2^(OUT_W-1), clamp likewise; otherwise store as-is.
    - Write the result to shadow[ch]. If ch==N_CH-1 go to DONE, else ch++ and go to MUL.
  - DONE: data_out <= shadow, sat_flags <= shadow_sat, valid <= 1, go to IDLE.
- Latency:
  - Counting the start edge as edge 0, DONE executes at edge 2*N_CH+1.
  - valid is high for the single cycle after that edge (edge 7 for N_CH=3).
  - Each cycle with CE=0 extends latency by one.
- valid: cleared on every edge that does not execute DONE, including edges with CE=0.
- busy: registered; 1 from the edge after start is accepted until the DONE edge; 0 in IDLE.
- Back-to-back starts: start=1 on the DONE edge is ignored (FSM not yet in IDLE). A start is accepted on the following edge.
- overrun: set when start=1 and busy=1 with CE=1; cleared only by reset. start while busy has no other effect.
- data_out holds the previous results between valid pulses.

Test Plan:
- Reset, then adc ch0=4095 with default coefficients, start -> valid at edge 7 exactly once; data_out ch0 = 536739840 (4095.0); busy high edges 1..7; sat_flags=0.
- Write ch1 gain=0x00A000 (10.0), offset=-2621440 (-20.0), adc ch1=100, start -> data_out ch1 = 128450560 (980.0), sat_flags[1]=0.
- Write ch2 gain=0xFFFFFF, offset=0, adc ch2=4095, start -> data_out ch2 = 137438953471 (2^37-1), sat_flags[2]=1. Then write gain=0x001000, rerun -> sat_flags[2]=0.
- Pulse start at edges 0 and 3 -> single valid at edge 7, overrun=1 and stays set. Start at edge 8 is accepted (valid at edge 15); overrun still 1.
- Write ch0 gain=2.0 at edge 2 of a conversion -> that conversion uses the old gain; the next conversion doubles the ch0 result. Also: CE=0 for 2 cycles mid-conversion -> valid moves to edge 9.
- rst=0 at edge 3 mid-conversion -> no valid, data_out=0, busy=0, coefficients back to defaults; next start completes normally.
